// File: rtl/fifo_pkg.sv
// Shared async-FIFO package: Gray/binary conversion helpers and default sizing.
// Used by the write-side pointer block, the read-side block and fifo_mem instances.
package fifo_pkg;

    localparam int FIFO_ADDRSIZE_DEFAULT = 4;

    // 32-bit binary to Gray; callers truncate to their pointer width.
    function automatic logic [31:0] bin2gray(input logic [31:0] b);
        return b ^ (b >> 1);
    endfunction

    // 32-bit Gray to binary; callers zero-extend narrower Gray values on entry.
    function automatic logic [31:0] gray2bin(input logic [31:0] g);
        logic [31:0] b;
        b[31] = g[31];
        for (int i = 30; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/fifo_sync_r2w.sv
// Multi-flop synchronizer for a Gray pointer crossing into the local clock domain.
// Built for the read-to-write path; the write-to-read path reuses it mirror-wise.
module fifo_sync_r2w #(
    parameter int WIDTH  = 5,
    parameter int STAGES = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] sync_q [STAGES];

    // Shift the asynchronous pointer through the flop chain; clear all stages on reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < STAGES; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q[0] <= d_i;
            for (int i = 1; i < STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/fifo_wptr_full.sv
// Write-side pointer and full-flag generator of the async FIFO.
// Produces the binary write address, registered full flag and pessimistic fill level,
// and exports a Gray write pointer to the read domain. The read pointer is brought in
// through an internal synchronizer; nothing else looks at the raw rptr input.
// Optional almost-full output is enabled by defining FIFO_ALMOST_FULL_EN.
module fifo_wptr_full
    import fifo_pkg::*;
#(
    parameter int ADDRSIZE    = FIFO_ADDRSIZE_DEFAULT,
    parameter int SYNC_STAGES = 2,
    parameter int AFULL_LEVEL = (1 << ADDRSIZE) - 2
) (
    input  logic                wclk,
    input  logic                wrst,
    input  logic                winc,
    input  logic [ADDRSIZE:0]   rptr,
    output logic                wclken,
    output logic [ADDRSIZE-1:0] waddr,
    output logic                wfull,
    output logic [ADDRSIZE:0]   wptr,
    output logic [ADDRSIZE:0]   wfill
`ifdef FIFO_ALMOST_FULL_EN
    ,
    output logic                awfull
`endif
);

    localparam int DEPTH = 1 << ADDRSIZE;

    // Reject configurations the pointer arithmetic cannot support.
    generate
        if (SYNC_STAGES < 2) begin : g_bad_sync
            $error("fifo_wptr_full: SYNC_STAGES must be at least 2");
        end
        if (AFULL_LEVEL < 0 || AFULL_LEVEL > DEPTH) begin : g_bad_afull
            $error("fifo_wptr_full: AFULL_LEVEL must lie in 0..DEPTH");
        end
    endgenerate

    logic [ADDRSIZE:0] wbin_q, wbin_d;
    logic [ADDRSIZE:0] wptr_q, wgray_d;
    logic              wfull_q, wfull_d;
    logic [ADDRSIZE:0] wfill_q, wfill_d;
    logic [ADDRSIZE:0] wq_rptr;
    logic [ADDRSIZE:0] rbin_sync;
    logic              push;

    fifo_sync_r2w #(
        .WIDTH  (ADDRSIZE + 1),
        .STAGES (SYNC_STAGES)
    ) u_sync_r2w (
        .clk_i (wclk),
        .rst_i (wrst),
        .d_i   (rptr),
        .q_o   (wq_rptr)
    );

    // Next pointer, Gray image, full compare and fill level from the synchronized rptr.
    // Full means the write pointer is exactly one lap (DEPTH) ahead: in Gray that is
    // the two top bits inverted and the rest equal.
    always_comb begin
        push      = winc & ~wfull_q;
        wbin_d    = wbin_q + (ADDRSIZE+1)'(push);
        wgray_d   = (ADDRSIZE+1)'(bin2gray(32'(wbin_d)));
        rbin_sync = (ADDRSIZE+1)'(gray2bin(32'(wq_rptr)));
        wfull_d   = (wgray_d == {~wq_rptr[ADDRSIZE:ADDRSIZE-1], wq_rptr[ADDRSIZE-2:0]});
        wfill_d   = wbin_d - rbin_sync;
    end

    // Pointer, full and fill registers; the binary counter wraps naturally.
    always_ff @(posedge wclk) begin
        if (wrst) begin
            wbin_q  <= '0;
            wptr_q  <= '0;
            wfull_q <= 1'b0;
            wfill_q <= '0;
        end else begin
            wbin_q  <= wbin_d;
            wptr_q  <= wgray_d;
            wfull_q <= wfull_d;
            wfill_q <= wfill_d;
        end
    end

`ifdef FIFO_ALMOST_FULL_EN
    logic awfull_q, awfull_d;

    // Almost-full threshold compare on the next fill level, registered alongside wfill.
    always_comb begin
        awfull_d = (wfill_d >= (ADDRSIZE+1)'(AFULL_LEVEL));
    end

    // Almost-full register.
    always_ff @(posedge wclk) begin
        if (wrst) begin
            awfull_q <= 1'b0;
        end else begin
            awfull_q <= awfull_d;
        end
    end

    assign awfull = awfull_q;
`endif

    // Memory write enable must drop immediately when full or in reset.
    assign wclken = winc & ~wfull_q & ~wrst;
    assign waddr  = wbin_q[ADDRSIZE-1:0];
    assign wfull  = wfull_q;
    assign wptr   = wptr_q;
    assign wfill  = wfill_q;

endmodule

// File: tb/tb_fifo_wptr_full.sv
// Bench for fifo_wptr_full (ADDRSIZE=4, SYNC_STAGES=2, DEPTH=16).
// Inputs change on the falling edge; wclken is checked before the rising edge,
// registered outputs 1 time unit after it.
module tb_fifo_wptr_full;

    localparam int A     = 4;
    localparam int DEPTH = 16;
    localparam int AFULL = DEPTH - 2;

    logic         wclk;
    logic         wrst;
    logic         winc;
    logic [A:0]   rptr;
    logic         wclken;
    logic [A-1:0] waddr;
    logic         wfull;
    logic [A:0]   wptr;
    logic [A:0]   wfill;
`ifdef FIFO_ALMOST_FULL_EN
    logic         awfull;
`endif

    int total = 0;
    int bad   = 0;

    // Reference model: counts of words written, reader position seen through
    // a two-cycle synchronizer delay (queue of read counts).
    int m_wcnt;
    int m_fill;
    bit m_full;
    int m_seen_q[$];

    fifo_wptr_full #(
        .ADDRSIZE    (A),
        .SYNC_STAGES (2),
        .AFULL_LEVEL (AFULL)
    ) dut (
        .wclk   (wclk),
        .wrst   (wrst),
        .winc   (winc),
        .rptr   (rptr),
        .wclken (wclken),
        .waddr  (waddr),
        .wfull  (wfull),
        .wptr   (wptr),
        .wfill  (wfill)
`ifdef FIFO_ALMOST_FULL_EN
        ,
        .awfull (awfull)
`endif
    );

    // Clock block.
    initial wclk = 1'b0;
    always #5 wclk = ~wclk;

    // Absolute time limit so the run always terminates.
    initial begin
        #200000;
        $display("FAIL timeout: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

    function automatic logic [A:0] gray5(input int b);
        int m;
        m = b & 31;
        return (A+1)'(m ^ (m >> 1));
    endfunction

    task automatic check(input string name, input int idx, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s[%0d]: got=%0d want=%0d", name, idx, act, exp);
        end
    endtask

    task automatic model_reset();
        m_wcnt = 0;
        m_fill = 0;
        m_full = 0;
        m_seen_q = '{0, 0};
    endtask

    // One clock edge of the reference model.
    task automatic model_edge(input bit r, input bit w, input int rd);
        int seen;
        if (r) begin
            model_reset();
        end else begin
            if (w && !m_full) m_wcnt = (m_wcnt + 1) % 32;
            seen = m_seen_q.pop_back();
            m_seen_q.push_front(rd & 31);
            m_fill = (m_wcnt - seen) & 31;
            m_full = (m_fill == DEPTH);
        end
    endtask

    int step_no = 0;

    // Driver: apply one cycle of inputs, check wclken pre-edge and all registers post-edge.
    task automatic step(input bit r, input bit w, input int rd);
        @(negedge wclk);
        wrst = r;
        winc = w;
        rptr = gray5(rd);
        #1;
        check("wclken", step_no, int'(wclken), int'(w && !m_full && !r));
        @(posedge wclk);
        #1;
        model_edge(r, w, rd);
        check("waddr", step_no, int'(waddr), m_wcnt % DEPTH);
        check("wfull", step_no, int'(wfull), int'(m_full));
        check("wfill", step_no, int'(wfill), m_fill);
        check("wptr",  step_no, int'(wptr),  int'(gray5(m_wcnt)));
`ifdef FIFO_ALMOST_FULL_EN
        check("awfull", step_no, int'(awfull), int'(m_fill >= AFULL));
`endif
        step_no++;
    endtask

    typedef struct {
        bit         rst;
        bit         winc;
        int         rd;
        bit         e_wclken;
        int         e_waddr;
        bit         e_wfull;
        int         e_wfill;
        logic [A:0] e_wptr;
    } vec_t;

    vec_t vecs[24];

    initial begin
        int n;
        int rd;
        wrst = 1'b1;
        winc = 1'b0;
        rptr = '0;
        model_reset();

        // Reset with winc held high, then 16 accepted pushes, then a refused 17th.
        vecs[0] = '{1, 1, 0, 0, 0, 0, 0, 5'b00000};
        vecs[1] = '{1, 1, 0, 0, 0, 0, 0, 5'b00000};
        for (int i = 1; i <= 16; i++) begin
            vecs[i+1] = '{0, 1, 0, 1, i % 16, (i == 16), i, gray5(i)};
        end
        vecs[18] = '{0, 1, 0, 0, 0, 1, 16, 5'b11000};
        // Reader advances to 1: full holds for two edges, drops on the third.
        vecs[19] = '{0, 0, 1, 0, 0, 1, 16, 5'b11000};
        vecs[20] = '{0, 0, 1, 0, 0, 1, 16, 5'b11000};
        vecs[21] = '{0, 0, 1, 0, 0, 0, 15, 5'b11000};
        // One push accepted into the freed slot, then full again and further winc refused.
        vecs[22] = '{0, 1, 1, 1, 1, 1, 16, 5'b11001};
        vecs[23] = '{0, 1, 1, 0, 1, 1, 16, 5'b11001};

        for (int i = 0; i < 24; i++) begin
            @(negedge wclk);
            wrst = vecs[i].rst;
            winc = vecs[i].winc;
            rptr = gray5(vecs[i].rd);
            #1;
            check("vec_wclken", i, int'(wclken), int'(vecs[i].e_wclken));
            @(posedge wclk);
            #1;
            model_edge(vecs[i].rst, vecs[i].winc, vecs[i].rd);
            check("vec_waddr", i, int'(waddr), vecs[i].e_waddr);
            check("vec_wfull", i, int'(wfull), int'(vecs[i].e_wfull));
            check("vec_wfill", i, int'(wfill), vecs[i].e_wfill);
            check("vec_wptr",  i, int'(wptr),  int'(vecs[i].e_wptr));
        end

        // Wrap: 40 pushes, reader follows the post-push write count four edges behind.
        step(1, 0, 0);
        for (int k = 0; k < 40; k++) begin
            rd = (k + 1 - 4 > 0) ? (k + 1 - 4) : 0;
            step(0, 1, rd);
            check("wrap_nofull", k, int'(wfull), 0);
            check("wrap_fill_le6", k, int'(wfill <= 6), 1);
        end
        check("wrap_count", 0, int'(wptr), int'(gray5(40)));

        // Mid-operation reset with a pending write.
        step(1, 0, 0);
        for (int k = 0; k < 7; k++) step(0, 1, 0);
        check("midop_addr", 0, int'(waddr), 7);
        step(1, 1, 0);
        check("midop_rst_addr", 0, int'(waddr), 0);
        check("midop_rst_ptr", 0, int'(wptr), 0);

        // Almost-full region: fill to 15 with the reader parked at 0.
        for (int k = 0; k < 15; k++) step(0, 1, 0);
        check("afill_15", 0, int'(wfill), 15);

        // Randomized traffic with a well-behaved reader (one Gray step per cycle, never past writes).
        step(1, 0, 0);
        rd = 0;
        for (int k = 0; k < 600; k++) begin
            bit r;
            bit w;
            r = ($urandom_range(0, 99) == 0);
            w = ($urandom_range(0, 3) != 0);
            if (!r && ($urandom_range(0, 2) == 0) && (((m_wcnt - rd) & 31) != 0)) begin
                rd = (rd + 1) % 32;
            end
            if (r) rd = 0;
            step(r, w, rd);
            if (k == 300) begin
                n = 0;
                while (!m_full && n < 64) begin
                    step(0, 1, rd);
                    n++;
                end
                check("rand_reach_full", k, int'(wfull), 1);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
